// File: rtl/rf_pkg.sv
// Shared types and helpers for the mips_16 multi-port register file.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_t;

  localparam logic [15:0] CTRL_RESET_DEFAULT = 16'h973F;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Bulk-clear sequencer: walks idx over entries 1..DEPTH-1, one entry per clock.
//   state | meaning
//   IDLE  | waiting for clr_req
//   CLEAR | zeroing entry idx this cycle
//   DONE  | clear finished, clr_done pulse
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  rf_clr_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (idx_q == IDX_LAST) state_d = DONE;
        else                   idx_d   = idx_q + ADDR_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they leave a flop.
  always_comb begin
    clr_busy_d = (state_d != IDLE);
    clr_done_d = (state_d == DONE);
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_idx  = idx_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with boot-control entry 0 and bulk-clear engine.
// Optional RF_BYPASS_EN forwards in-flight write/clear data to the read ports.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 3,
  parameter int                RD_PORTS   = 2,
  parameter logic [DATA_W-1:0] CTRL_RESET = DATA_W'(CTRL_RESET_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]            ctrl_data,
  input  logic                         ctrl_done,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_accept;
  logic [ADDR_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_w;

  rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  assign wr_accept = wr_en && (wr_addr != '0) && !clr_busy;

  // Slot 0 of mem is never written; the boot-control word lives in ctrl_q.
  always_comb begin
    mem_d = mem_q;
    if (wr_accept) mem_d[wr_addr] = wr_data;
    if (clr_we)    mem_d[clr_idx] = '0;
    mem_d[0] = '0;
    ctrl_d = ctrl_done ? '0 : ctrl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ctrl_q <= CTRL_RESET;
    end else begin
      mem_q  <= mem_d;
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_a    = '0;
    rd_w    = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_a = rd_addr[k*ADDR_W +: ADDR_W];
      rd_w = (rd_a == '0) ? '0 : mem_q[rd_a];
`ifdef RF_BYPASS_EN
      if (wr_accept && (rd_a == wr_addr)) rd_w = wr_data;
      if (clr_we && (rd_a == clr_idx))    rd_w = '0;
`endif
      rd_data[k*DATA_W +: DATA_W] = rd_w;
    end
  end

  assign ctrl_data = ctrl_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (default parameters, either bypass build).
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] ctrl_data;
  logic        ctrl_done;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mdl [8];
  logic [15:0] mdl_ctrl;
  logic [15:0] got, exp;

  register_file_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ctrl_data (ctrl_data),
    .ctrl_done (ctrl_done),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] port_data(input int k);
    return rd_data[k*16 +: 16];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    mdl_ctrl = 16'h973F;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    if (a != 3'd0) mdl[a] = d;
    #1 wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; ctrl_done = 1'b0; clr_req = 1'b0;
    mdl_reset();
    #12;
    n_checks++;
    if (ctrl_data !== mdl_ctrl) begin
      n_errors++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl_data, mdl_ctrl);
    end
    n_checks++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      n_errors++; $display("FAIL reset_status got=%b exp=00", {clr_busy, clr_done});
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      exp_q.push_back(mdl[a]);
      exp_q.push_back(mdl[7 - a]);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = port_data(k); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL reset_read a=%0d port=%0d got=%h exp=%h", a, k, got, exp);
        end
      end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write();
    write_word(3'd5, 16'hBEEF);
    rd_addr = {3'd5, 3'd5};
    exp_q.push_back(mdl[5]); exp_q.push_back(mdl[5]);
    #1;
    for (int k = 0; k < 2; k++) begin
      got = port_data(k); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL write_beef port=%0d got=%h exp=%h", k, got, exp);
      end
    end
    write_word(3'd0, 16'h1234);
    write_word(3'd2, 16'h1111);
    write_word(3'd6, 16'hC0DE);
    n_checks++;
    if (ctrl_data !== mdl_ctrl) begin
      n_errors++; $display("FAIL write_addr0_ctrl got=%h exp=%h", ctrl_data, mdl_ctrl);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      exp_q.push_back(mdl[a]);
      exp_q.push_back(mdl[7 - a]);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = port_data(k); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL write_read a=%0d port=%0d got=%h exp=%h", a, k, got, exp);
        end
      end
    end
  endtask

  task automatic test_ctrl_done();
    @(negedge clk) ctrl_done = 1'b1;
    @(posedge clk) mdl_ctrl = 16'h0;
    #1 ctrl_done = 1'b0;
    n_checks++;
    if (ctrl_data !== mdl_ctrl) begin
      n_errors++; $display("FAIL ctrl_done got=%h exp=%h", ctrl_data, mdl_ctrl);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      exp_q.push_back(mdl[a]);
      exp_q.push_back(mdl[7 - a]);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = port_data(k); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL ctrl_done_read a=%0d port=%0d got=%h exp=%h", a, k, got, exp);
        end
      end
    end
  endtask

  task automatic test_clear();
    int done_cnt;
    done_cnt = 0;
    for (int i = 1; i < 8; i++) write_word(3'(i), 16'hFFFF);
    for (int c = 0; c < 10; c++) exp_q.push_back({14'd0, (c <= 7), (c == 7)});
    @(negedge clk) clr_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      got = {14'd0, clr_busy, clr_done}; exp = exp_q.pop_front(); n_checks++;
      if (clr_done) done_cnt++;
      if (got !== exp) begin
        n_errors++; $display("FAIL clear_status c=%0d got=%b exp=%b", c, got[1:0], exp[1:0]);
      end
      @(negedge clk);
      if (c == 0) begin
        clr_req = 1'b0; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555;
      end
      if (c == 6) wr_en = 1'b0;
    end
    for (int i = 1; i < 8; i++) mdl[i] = 16'h0;
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++; $display("FAIL clear_done_count got=%0d exp=1", done_cnt);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      exp_q.push_back(mdl[a]);
      exp_q.push_back(mdl[7 - a]);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = port_data(k); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL clear_read a=%0d port=%0d got=%h exp=%h", a, k, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt;
    done_cnt = 0;
    for (int i = 1; i < 8; i++) write_word(3'(i), 16'h1000 + 16'(i));
    @(negedge clk) clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    mdl_reset();
    #1;
    n_checks++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      n_errors++; $display("FAIL midclr_status got=%b exp=00", {clr_busy, clr_done});
    end
    n_checks++;
    if (ctrl_data !== mdl_ctrl) begin
      n_errors++; $display("FAIL midclr_ctrl got=%h exp=%h", ctrl_data, mdl_ctrl);
    end
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(7 - a), 3'(a)};
      exp_q.push_back(mdl[a]);
      exp_q.push_back(mdl[7 - a]);
      #1;
      for (int k = 0; k < 2; k++) begin
        got = port_data(k); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL midclr_read a=%0d port=%0d got=%h exp=%h", a, k, got, exp);
        end
      end
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (clr_done || clr_busy) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_errors++; $display("FAIL midclr_no_done got=%0d active cycles exp=0", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    write_word(3'd2, 16'h2222);
    write_word(3'd5, 16'h5A5A);
    for (int c = 0; c < 19; c++)
      exp_q.push_back({14'd0, (c <= 7) || (c >= 9 && c <= 16), (c == 7) || (c == 16)});
    @(negedge clk) clr_req = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #1;
      got = {14'd0, clr_busy, clr_done}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL b2b_status c=%0d got=%b exp=%b", c, got[1:0], exp[1:0]);
      end
      @(negedge clk);
      if (c == 2) ctrl_done = 1'b1;
      if (c == 3) begin ctrl_done = 1'b0; mdl_ctrl = 16'h0; end
      if (c == 17) clr_req = 1'b0;
    end
    for (int i = 1; i < 8; i++) mdl[i] = 16'h0;
    n_checks++;
    if (ctrl_data !== mdl_ctrl) begin
      n_errors++; $display("FAIL b2b_ctrl_done got=%h exp=%h", ctrl_data, mdl_ctrl);
    end
    rd_addr = {3'd5, 3'd2};
    exp_q.push_back(mdl[2]); exp_q.push_back(mdl[5]);
    #1;
    for (int k = 0; k < 2; k++) begin
      got = port_data(k); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL b2b_read port=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_bypass();
    write_word(3'd3, 16'h0033);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
    rd_addr = {3'd4, 3'd3};
`ifdef RF_BYPASS_EN
    exp_q.push_back(16'hA5A5);
`else
    exp_q.push_back(mdl[3]);
`endif
    exp_q.push_back(mdl[4]);
    #1;
    for (int k = 0; k < 2; k++) begin
      got = port_data(k); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL bypass_pre port=%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(posedge clk) mdl[3] = 16'hA5A5;
    #1 wr_en = 1'b0;
    exp_q.push_back(mdl[3]); exp_q.push_back(mdl[4]);
    for (int k = 0; k < 2; k++) begin
      got = port_data(k); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL bypass_post port=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ctrl_done();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the mips_16 datapath: one synchronous write port, `RD_PORTS` asynchronous read ports and a configurable data width and depth. It keeps the boot-control register at entry 0, which is loaded at reset, exported continuously and cleared by a done strobe. It adds a sequenced bulk-clear engine with a request/busy/done handshake. It sits between the decode stage (read ports) and the write-back stage (write port).

## Interface
- `DATA_W`, 16, register width in bits
- `ADDR_W`, 3, address width; DEPTH = 2**ADDR_W entries (min 2)
- `RD_PORTS`, 2, number of read ports (1..4)
- `CTRL_RESET`, 16'h973F, reset value of entry 0 (boot-control word)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `wr_en`  in  1  write enable
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `rd_addr`  in  RD_PORTS*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  RD_PORTS*DATA_W  packed read data, same packing
- `ctrl_data`  out  DATA_W  stored value of entry 0
- `ctrl_done`  in  1  clears entry 0 at the next edge
- `clr_req`  in  1  starts a bulk clear of entries 1..DEPTH-1
- `clr_busy`  out  1  clear engine active
- `clr_done`  out  1  one-cycle pulse on clear completion

## Operation
- **Reset (rst_n=0):**
  - entry 0 = CTRL_RESET; entries 1..DEPTH-1 = 0.
  - FSM = IDLE, clr_busy = 0, clr_done = 0.
  - ctrl_data = CTRL_RESET; all rd_data = 0.
- **Reads:**
  - Combinational: rd_data[k] = array[rd_addr[k]].
  - Any port addressing entry 0 reads 0.
- **Writes:**
  - On the rising edge when wr_en=1 and wr_addr≠0.
  - Writes to address 0 are discarded.
  - Writes with clr_busy=1 are discarded.
- **Entry 0:**
  - Changes only on reset or ctrl_done.
  - ctrl_done=1 sets it to 0 at the edge, and takes effect even while clr_busy=1.
- **Clear FSM:**
  - IDLE: clr_req=1 → CLEAR with idx=1.
  - CLEAR: at each edge write 0 to array[idx]. If idx==DEPTH-1 → DONE, else idx+1.
  - DONE: clr_done=1 for one cycle, then → IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - clr_req is ignored when not in IDLE; a clr_req held high restarts a clear after returning to IDLE.
- **idx width:** ADDR_W bits, no wrap; the terminal compare stops it at DEPTH-1.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- Clear example: clr_req sampled at edge T0.
  - clr_busy rises after T0.
  - Entries 1..DEPTH-1 clear at edges T1..T(DEPTH-1).
  - clr_done is high in the cycle after T(DEPTH-1), i.e. DEPTH cycles after request for DEPTH=8.
  - clr_busy falls after edge T(DEPTH).
- Reset mid-clear: the asynchronous reset aborts it immediately and all outputs return to reset values; there is no clr_done pulse.
- Simultaneous clr_req and wr_en in IDLE: the write commits at T0, then the clear overwrites it.
- Outputs clr_busy and clr_done are registered. rd_data and ctrl_data follow the array state, combinationally from registers.

## Configuration
- `RF_BYPASS_EN` defined:
  - A read port whose address equals wr_addr, with an accepted write this cycle (wr_en=1, wr_addr≠0, not busy), returns wr_data combinationally.
  - During CLEAR, a port reading idx returns 0.
- Not defined: reads return the stored value only; the new data is visible the cycle after the edge.

## Structure
- Package `rf_pkg`:
  - state enum rf_clr_state_t {IDLE, CLEAR, DONE}
  - localparam default CTRL_RESET
  - helper function for DEPTH from ADDR_W
- Sub-module `rf_clear_fsm`: owns state and idx; outputs clr_we, clr_idx, clr_busy, clr_done. The top module owns the array, the read muxes and the bypass.

## Test plan
- Reset (defaults) → ctrl_data=16'h973F, rd_data all 0, clr_busy=0.
- Write 16'hBEEF to addr 5; read on both ports next cycle → 16'hBEEF. Write 16'h1234 to addr 0 → ctrl_data still 16'h973F, read of addr 0 = 0.
- Pulse ctrl_done → ctrl_data=0 after one edge. Registers 1..7 unchanged.
- Fill 1..7 with 16'hFFFF; pulse clr_req:
  - clr_busy high for 8 cycles, clr_done pulses exactly once in cycle 8.
  - All entries read 0.
  - wr_en during busy has no effect.
- Assert rst_n=0 at clear cycle 3 → clr_busy=0 immediately, no clr_done, entries 1..7 = 0, entry 0 = 16'h973F.
- With RF_BYPASS_EN: wr_en, addr 3, 16'hA5A5 and rd_addr=3 in the same cycle → rd_data=16'hA5A5 before the edge. Without the macro → old value before the edge, 16'hA5A5 after it.
